// File: rtl/sobel_pkg.sv
// Shared constants, types and helpers for the Sobel gradient core.
//   PIX_W : pixel width (unsigned)
//   THR_W : threshold width (unsigned)
//   SUM_W : width of one weighted 1-2-1 row/column sum (0..4*max pixel)
//   MAG_W : width of signed gradients and of the unsigned magnitude
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int THR_W = 8;
    localparam int SUM_W = PIX_W + 2;
    localparam int MAG_W = PIX_W + 3;

    typedef logic [PIX_W-1:0]        pix_t;
    typedef logic [THR_W-1:0]        thr_t;
    typedef logic [SUM_W-1:0]        sum_t;
    typedef logic signed [MAG_W-1:0] grad_t;
    typedef logic [MAG_W-1:0]        mag_t;

    // a + 2*b + c, widened first so the sum cannot wrap.
    function automatic sum_t wsum(input pix_t a, input pix_t b, input pix_t c);
        return sum_t'(a) + (sum_t'(b) << 1) + sum_t'(c);
    endfunction

    // Signed difference of two unsigned weighted sums. One extra bit
    // holds the full -1020..+1020 range.
    function automatic grad_t sdiff(input sum_t pos, input sum_t neg);
        return grad_t'({1'b0, pos}) - grad_t'({1'b0, neg});
    endfunction

endpackage

// File: rtl/sobel_abs.sv
// Combinational absolute value of a signed gradient.
//   grad    : signed gradient (grad_t)
//   abs_val : |grad| as unsigned magnitude (mag_t)
// Gradients never reach the most negative code, so negation cannot overflow.
module sobel_abs
    import sobel_pkg::*;
(
    input  grad_t grad,
    output mag_t  abs_val
);

    assign abs_val = grad[MAG_W-1] ? mag_t'(-grad) : mag_t'(grad);

endmodule

// File: rtl/sobel_gradient.sv
// 3x3 Sobel edge detector core, 3-stage pipeline, one window per cycle.
//   clk       : rising-edge clock
//   rst_n     : synchronous reset, active low
//   in_valid  : P0..P8 and T carry a window this cycle
//   P0..P8    : window row-major, P0 top-left, P4 centre, P8 bottom-right
//   T         : edge threshold, travels down the pipe with its window
//   out_valid : mag/Dop carry a result this cycle
//   mag       : |Gx| + |Gy|
//   Dop       : edge flag, 1 when mag > T (strictly greater)
//
// Handshake: valid-only streaming. A window is accepted on every rising edge
// with in_valid=1; there is no ready and no stall. out_valid is in_valid
// delayed by exactly 3 cycles. mag/Dop hold their last value on bubbles.
module sobel_gradient
    import sobel_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  pix_t P0,
    input  pix_t P1,
    input  pix_t P2,
    input  pix_t P3,
    input  pix_t P4,
    input  pix_t P5,
    input  pix_t P6,
    input  pix_t P7,
    input  pix_t P8,
    input  thr_t T,
    output logic out_valid,
    output mag_t mag,
    output logic Dop
);

    // Stage 1: weighted sums. Gx = right col - left col, Gy = bottom row - top row.
    logic s1_valid;
    sum_t s1_gx_pos, s1_gx_neg, s1_gy_pos, s1_gy_neg;
    thr_t s1_t;

    // Stage 2: absolute gradients.
    logic s2_valid;
    mag_t s2_ax, s2_ay;
    thr_t s2_t;

    grad_t gx, gy;
    mag_t  abs_x, abs_y;
    mag_t  mag_sum;

    // P4 has zero weight in both kernels.
    logic unused_p4;
    assign unused_p4 = ^P4;

    assign gx = sdiff(s1_gx_pos, s1_gx_neg);
    assign gy = sdiff(s1_gy_pos, s1_gy_neg);

    sobel_abs u_abs_x (.grad(gx), .abs_val(abs_x));
    sobel_abs u_abs_y (.grad(gy), .abs_val(abs_y));

    // Max 2040 fits MAG_W, no saturation needed.
    assign mag_sum = s2_ax + s2_ay;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_gx_pos <= '0;
            s1_gx_neg <= '0;
            s1_gy_pos <= '0;
            s1_gy_neg <= '0;
            s1_t      <= '0;
            s2_valid  <= 1'b0;
            s2_ax     <= '0;
            s2_ay     <= '0;
            s2_t      <= '0;
            out_valid <= 1'b0;
            mag       <= '0;
            Dop       <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            // Data registers only load for real windows.
            if (in_valid) begin
                s1_gx_pos <= wsum(P2, P5, P8);
                s1_gx_neg <= wsum(P0, P3, P6);
                s1_gy_pos <= wsum(P6, P7, P8);
                s1_gy_neg <= wsum(P0, P1, P2);
                s1_t      <= T;
            end
            if (s1_valid) begin
                s2_ax <= abs_x;
                s2_ay <= abs_y;
                s2_t  <= s1_t;
            end
            if (s2_valid) begin
                mag <= mag_sum;
                Dop <= (mag_sum > mag_t'(s2_t));
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient.sv
module tb_sobel_gradient;
    import sobel_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid;
    logic [8:0][7:0]  pix;
    logic [7:0]       t;
    logic             out_valid;
    mag_t             mag;
    logic             dop;

    sobel_gradient dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .P0(pix[0]), .P1(pix[1]), .P2(pix[2]), .P3(pix[3]), .P4(pix[4]),
        .P5(pix[5]), .P6(pix[6]), .P7(pix[7]), .P8(pix[8]),
        .T(t), .out_valid(out_valid), .mag(mag), .Dop(dop)
    );

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;
    logic [MAG_W:0] exp_q[$];   // {dop, mag}

    typedef struct packed {
        logic [8:0][7:0] p;
        logic [7:0]      t;
        logic [10:0]     mag;
        logic            dop;
    } vec_t;

    localparam int NV = 16;
    vec_t vt[NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0][7:0] px(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        logic [8:0][7:0] r;
        r[0] = a0[7:0]; r[1] = a1[7:0]; r[2] = a2[7:0];
        r[3] = a3[7:0]; r[4] = a4[7:0]; r[5] = a5[7:0];
        r[6] = a6[7:0]; r[7] = a7[7:0]; r[8] = a8[7:0];
        return r;
    endfunction

    function automatic vec_t mk(input logic [8:0][7:0] p, input int tt, input int m, input int d);
        vec_t v;
        v.p = p; v.t = tt[7:0]; v.mag = m[10:0]; v.dop = d[0];
        return v;
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic int ref_mag(input logic [8:0][7:0] p);
        int q[9];
        int gx, gy;
        for (int i = 0; i < 9; i++) q[i] = int'(p[i]);
        gx = (q[2] + 2*q[5] + q[8]) - (q[0] + 2*q[3] + q[6]);
        gy = (q[6] + 2*q[7] + q[8]) - (q[0] + 2*q[1] + q[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [8:0][7:0] p, input int tt, input int em, input int ed);
        @(negedge clk);
        in_valid = 1'b1;
        pix      = p;
        t        = tt[7:0];
        if (mon_en) exp_q.push_back({ed[0], em[10:0]});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < 9; i++) pix[i] = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin : monitor
        logic [MAG_W:0] e;
        #1;
        if (mon_en && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("stream_mag", int'(mag), int'(e[MAG_W-1:0]));
                check("stream_dop", int'(dop), int'(e[MAG_W]));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin : stim
        logic [8:0][7:0] rp;
        int rt, rm, lim, waited;

        vt[0]  = mk(px(0,0,0, 0,0,0, 0,0,0),                       20, 0,    0);
        vt[1]  = mk(px(200,200,200, 200,200,200, 200,200,200),     20, 0,    0);
        vt[2]  = mk(px(0,128,255, 0,128,255, 0,128,255),           20, 1020, 1);
        vt[3]  = mk(px(0,0,0, 128,128,128, 255,255,255),           20, 1020, 1);
        vt[4]  = mk(px(0,0,0, 0,0,10, 0,0,0),                      20, 20,   0);
        vt[5]  = mk(px(0,0,0, 0,0,11, 0,0,0),                      20, 22,   1);
        vt[6]  = mk(px(0,0,255, 0,0,255, 255,255,255),             20, 1530, 1);
        vt[7]  = mk(px(0,0,0, 0,0,255, 0,255,255),                 255, 1530, 1);
        vt[8]  = mk(px(255,0,0, 0,0,0, 0,0,0),                     20, 510,  1);
        vt[9]  = mk(px(0,0,0, 100,0,0, 0,0,0),                     199, 200, 1);
        vt[10] = mk(px(0,0,0, 100,0,0, 0,0,0),                     200, 200, 0);
        vt[11] = mk(px(0,0,0, 0,0,0, 0,0,0),                       0,  0,    0);
        vt[12] = mk(px(0,60,0, 0,0,0, 0,10,0),                     99, 100,  1);
        vt[13] = mk(px(10,20,30, 40,50,60, 70,80,90),              50, 320,  1);
        vt[14] = mk(px(255,0,255, 0,255,0, 255,0,255),             255, 0,   0);
        vt[15] = mk(px(0,0,0, 0,0,127, 0,0,0),                     255, 254, 0);

        rst_n    = 1'b0;
        in_valid = 1'b0;
        pix      = '0;
        t        = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_mag",       int'(mag),       0);
        check("reset_dop",       int'(dop),       0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Exact latency and hold-on-bubble for one window.
        send(vt[2].p, int'(vt[2].t), 0, 0);
        @(posedge clk); #1;
        check("lat_c1_out_valid", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("lat_c2_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_c3_out_valid", int'(out_valid), 1);
        check("lat_c3_mag",       int'(mag),       1020);
        check("lat_c3_dop",       int'(dop),       1);
        @(posedge clk); #1;
        check("bubble_out_valid", int'(out_valid), 0);
        check("bubble_mag_hold",  int'(mag),       1020);
        check("bubble_dop_hold",  int'(dop),       1);
        idle(2);

        // Directed table, back to back (T changes between windows).
        mon_en = 1'b1;
        for (int i = 0; i < NV; i++)
            send(vt[i].p, int'(vt[i].t), int'(vt[i].mag), int'(vt[i].dop));
        idle(2);
        // Same table with bubbles in between.
        for (int i = 0; i < NV; i++) begin
            send(vt[i].p, int'(vt[i].t), int'(vt[i].mag), int'(vt[i].dop));
            idle(i % 3);
        end

        // Random windows against the reference model.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                lim = ($urandom_range(0, 1) == 0) ? 15 : 255;
                for (int i = 0; i < 9; i++) rp[i] = 8'($urandom_range(0, lim));
                rt = $urandom_range(0, 255);
                rm = ref_mag(rp);
                send(rp, rt, rm, (rm > rt) ? 1 : 0);
            end else begin
                idle(1);
            end
        end
        idle(1);
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            idle(1);
            waited++;
        end
        check("drain_pending", exp_q.size(), 0);
        idle(2);
        mon_en = 1'b0;
        exp_q.delete();

        // Reset with three windows in flight; a window offered during reset is dropped.
        send(vt[2].p, 20, 0, 0);
        send(vt[3].p, 20, 0, 0);
        send(vt[6].p, 20, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        pix = vt[7].p;
        @(posedge clk); #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_mag",       int'(mag),       0);
        check("midrst_dop",       int'(dop),       0);
        @(negedge clk);
        @(posedge clk); #1;
        check("midrst2_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("postrst_out_valid", int'(out_valid), 0);
            check("postrst_mag",       int'(mag),       0);
        end

        // First window after reset arrives 3 cycles later.
        send(vt[5].p, 20, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("postrst_c2_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("postrst_c3_out_valid", int'(out_valid), 1);
        check("postrst_c3_mag",       int'(mag),       22);
        check("postrst_c3_dop",       int'(dop),       1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
